// File: rtl/cs_sample_feeder.sv
// cs_sample_feeder: buffers valid/ready samples in a FIFO and streams them to CS.X, flagging full-window Y cycles
//  clk_i       clock, all state on posedge
//  rst_ni      asynchronous active-low reset
//  in_data_i   sample from source          in_valid_i  sample valid
//  in_ready_o  FIFO not full
//  start_i     level run request
//  x_out_o     registered sample to CS.X   x_strobe_o  x_out_o is a new sample
//  y_valid_o   CS.Y covers WINDOW fresh contiguous samples
//  underrun_o  sticky, FIFO ran dry while streaming
//  level_o     FIFO occupancy              busy_o      not idle
module cs_sample_feeder #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int PRIME  = 8,
  parameter int WINDOW = 9,
  parameter int LAT    = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          start_i,
  output logic [DW-1:0] x_out_o,
  output logic          x_strobe_o,
  output logic          y_valid_o,
  output logic          underrun_o,
  output logic [AW:0]   level_o,
  output logic          busy_o
);
  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [AW:0] FULL_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PRIME_L = (AW + 1)'(PRIME);
  localparam logic [WW-1:0] WIN_L = WW'(WINDOW);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q;
  logic [DW-1:0] x_out_q, x_out_d;
  logic x_strobe_q, x_strobe_d, underrun_q, underrun_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [LAT-1:0] y_pipe_q;
  logic push, pop, empty, y_tap;
  assign in_ready_o = level_q != FULL_L;
  assign empty = level_q == '0;
  assign push = in_valid_i && in_ready_o;
  assign y_tap = x_strobe_q && (win_cnt_q == WIN_L);
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    x_strobe_d = 1'b0;
    x_out_d = x_out_q;
    underrun_d = underrun_q;
    win_cnt_d = '0;
    case (state_q)
      IDLE: state_d = start_i ? FILL : IDLE;
      FILL: state_d = !start_i ? IDLE : (level_q >= PRIME_L ? STREAM : FILL);
      STREAM: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (!empty) begin
          pop = 1'b1;
          x_strobe_d = 1'b1;
          x_out_d = mem_q[rd_ptr_q];
          win_cnt_d = (win_cnt_q == WIN_L) ? win_cnt_q : win_cnt_q + 1'b1;
        end else begin
          // No bypass: a same-cycle push into an empty FIFO still counts as a dry pop.
          underrun_d = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      x_out_q <= '0;
      x_strobe_q <= 1'b0;
      underrun_q <= 1'b0;
      win_cnt_q <= '0;
      y_pipe_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q <= level_q + (AW + 1)'(push) - (AW + 1)'(pop);
      x_out_q <= x_out_d;
      x_strobe_q <= x_strobe_d;
      underrun_q <= underrun_d;
      win_cnt_q <= win_cnt_d;
      // Shift register of LAT stages; truncation drops the oldest bit.
      y_pipe_q <= LAT'({y_pipe_q, y_tap});
    end
  end
  assign x_out_o = x_out_q;
  assign x_strobe_o = x_strobe_q;
  assign y_valid_o = y_pipe_q[LAT-1];
  assign underrun_o = underrun_q;
  assign level_o = level_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_cs_sample_feeder.sv
// tb_cs_sample_feeder: directed self-checking bench for cs_sample_feeder
module tb_cs_sample_feeder;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [7:0] in_data_i = '0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic start_i = 1'b0;
  logic [7:0] x_out_o;
  logic x_strobe_o, y_valid_o, underrun_o, busy_o;
  logic [4:0] level_o;
  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  int ycnt, cyc, ninth_cyc, first_y;
  always #5 clk_i = ~clk_i;
  cs_sample_feeder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .start_i(start_i), .x_out_o(x_out_o), .x_strobe_o(x_strobe_o),
    .y_valid_o(y_valid_o), .underrun_o(underrun_o), .level_o(level_o), .busy_o(busy_o)
  );
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (x_strobe_o) begin
      got.push_back(x_out_o);
      if (got.size() == 9) ninth_cyc = cyc;
    end
    if (y_valid_o) begin
      ycnt++;
      if (first_y < 0) first_y = cyc;
    end
  endtask
  task automatic clear_obs();
    got.delete();
    ycnt = 0;
    ninth_cyc = -1;
    first_y = -1;
  endtask
  task automatic do_reset();
    in_valid_i = 1'b0;
    start_i = 1'b0;
    in_data_i = '0;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    clear_obs();
  endtask
  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b1;
      in_data_i = 8'(base + 8'(i));
      tick();
    end
    in_valid_i = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready_o); end
    checks++; if (x_out_o !== 8'h00) begin errors++; $display("FAIL rst_x_out got %h exp 00", x_out_o); end
    checks++; if (x_strobe_o !== 1'b0) begin errors++; $display("FAIL rst_x_strobe got %b exp 0", x_strobe_o); end
    checks++; if (y_valid_o !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %b exp 0", y_valid_o); end
    checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
  endtask
  task automatic test_prime_stream();
    int start_cyc, fs;
    do_reset();
    push_n(8, 8'h01);
    checks++; if (level_o !== 5'd8) begin errors++; $display("FAIL prime_level got %0d exp 8", level_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL prime_idle_busy got %b exp 0", busy_o); end
    start_i = 1'b1;
    start_cyc = cyc;
    fs = -1;
    for (int c = 0; c < 30 && got.size() < 8; c++) begin
      tick();
      if (x_strobe_o) begin
        if (fs < 0) fs = cyc;
        checks++;
        if (level_o !== 5'(8 - got.size())) begin errors++; $display("FAIL prime_level_dec got %0d exp %0d", level_o, 8 - got.size()); end
      end
    end
    checks++; if (fs !== start_cyc + 3) begin errors++; $display("FAIL prime_first_strobe got cycle %0d exp %0d", fs, start_cyc + 3); end
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL prime_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL prime_data[%0d] got %h exp %h", i, got[i], 8'(i + 1)); end
    end
    start_i = 1'b0;
  endtask
  task automatic test_window();
    do_reset();
    start_i = 1'b1;
    push_n(20, 8'h30);
    for (int c = 0; c < 40 && !underrun_o; c++) tick();
    tick();
    checks++; if (got.size() !== 20) begin errors++; $display("FAIL win_count got %0d exp 20", got.size()); end
    if (got.size() == 20) begin
      checks++; if (got[19] !== 8'h43) begin errors++; $display("FAIL win_last got %h exp 43", got[19]); end
    end
    checks++; if (first_y !== ninth_cyc + 1) begin errors++; $display("FAIL win_first_y got cycle %0d exp %0d", first_y, ninth_cyc + 1); end
    checks++; if (ycnt !== 12) begin errors++; $display("FAIL win_y_count got %0d exp 12", ycnt); end
    checks++; if (underrun_o !== 1'b1) begin errors++; $display("FAIL win_underrun got %b exp 1", underrun_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL win_busy_fill got %b exp 1", busy_o); end
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL win_level got %0d exp 0", level_o); end
    start_i = 1'b0;
  endtask
  task automatic test_full();
    logic rdy, pushed;
    do_reset();
    push_n(16, 8'h50);
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready_o); end
    in_valid_i = 1'b1;
    in_data_i = 8'h60;
    tick(); tick(); tick();
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL full_hold_level got %0d exp 16", level_o); end
    start_i = 1'b1;
    pushed = 1'b0;
    for (int c = 0; c < 20 && !pushed; c++) begin
      rdy = in_ready_o;
      tick();
      if (rdy) pushed = 1'b1;
    end
    in_valid_i = 1'b0;
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL full_push_after_pop got strobes %0d exp 2", got.size()); end
    for (int c = 0; c < 40 && got.size() < 17; c++) tick();
    checks++; if (got.size() !== 17) begin errors++; $display("FAIL full_count got %0d exp 17", got.size()); end
    if (got.size() == 17) begin
      checks++; if (got[0] !== 8'h50) begin errors++; $display("FAIL full_first got %h exp 50", got[0]); end
      checks++; if (got[15] !== 8'h5f) begin errors++; $display("FAIL full_16th got %h exp 5f", got[15]); end
      checks++; if (got[16] !== 8'h60) begin errors++; $display("FAIL full_17th got %h exp 60", got[16]); end
    end
    start_i = 1'b0;
  endtask
  task automatic test_pause();
    do_reset();
    push_n(16, 8'h70);
    start_i = 1'b1;
    for (int c = 0; c < 30 && got.size() < 5; c++) tick();
    start_i = 1'b0;
    tick();
    checks++; if (x_strobe_o !== 1'b0) begin errors++; $display("FAIL pause_strobe got %b exp 0", x_strobe_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pause_busy got %b exp 0", busy_o); end
    checks++; if (level_o !== 5'd11) begin errors++; $display("FAIL pause_level got %0d exp 11", level_o); end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL pause_count got %0d exp 5", got.size()); end
    checks++; if (ycnt !== 0) begin errors++; $display("FAIL pause_y_early got %0d exp 0", ycnt); end
    tick(); tick();
    clear_obs();
    start_i = 1'b1;
    for (int c = 0; c < 40 && got.size() < 11; c++) tick();
    tick(); tick(); tick();
    checks++; if (got.size() !== 11) begin errors++; $display("FAIL resume_count got %0d exp 11", got.size()); end
    if (got.size() == 11) begin
      checks++; if (got[0] !== 8'h75) begin errors++; $display("FAIL resume_first got %h exp 75", got[0]); end
      checks++; if (got[10] !== 8'h7f) begin errors++; $display("FAIL resume_last got %h exp 7f", got[10]); end
    end
    checks++; if (first_y !== ninth_cyc + 1) begin errors++; $display("FAIL resume_first_y got cycle %0d exp %0d", first_y, ninth_cyc + 1); end
    checks++; if (ycnt !== 3) begin errors++; $display("FAIL resume_y_count got %0d exp 3", ycnt); end
    start_i = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    push_n(16, 8'h90);
    start_i = 1'b1;
    for (int c = 0; c < 40 && level_o != 5'd6; c++) tick();
    checks++; if (y_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_y got %b exp 1", y_valid_o); end
    checks++; if (x_out_o !== 8'h99) begin errors++; $display("FAIL mid_pre_x got %h exp 99", x_out_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (x_out_o !== 8'h00) begin errors++; $display("FAIL mid_x_out got %h exp 00", x_out_o); end
    checks++; if (x_strobe_o !== 1'b0) begin errors++; $display("FAIL mid_strobe got %b exp 0", x_strobe_o); end
    checks++; if (y_valid_o !== 1'b0) begin errors++; $display("FAIL mid_y_valid got %b exp 0", y_valid_o); end
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready_o); end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_post_in_ready got %b exp 1", in_ready_o); end
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL mid_post_level got %0d exp 0", level_o); end
  endtask
  task automatic test_wrap();
    int idx;
    logic rdy;
    do_reset();
    start_i = 1'b1;
    idx = 0;
    for (int c = 0; c < 400 && idx < 48; c++) begin
      in_valid_i = 1'b1;
      in_data_i = idx < 40 ? 8'(8'hA0 + idx) : 8'(8'hE0 + idx - 40);
      rdy = in_ready_o;
      tick();
      if (rdy) idx++;
      if (rdy && idx < 40 && idx % 3 == 0) begin
        in_valid_i = 1'b0;
        tick();
      end
    end
    in_valid_i = 1'b0;
    for (int c = 0; c < 60 && got.size() < 48; c++) tick();
    tick(); tick(); tick();
    checks++; if (got.size() !== 48) begin errors++; $display("FAIL wrap_count got %0d exp 48", got.size()); end
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL wrap_level got %0d exp 0", level_o); end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, got[i], 8'(8'hA0 + i)); end
    end
    start_i = 1'b0;
  endtask
  initial begin
    cyc = 0;
    clear_obs();
    test_reset();
    test_prime_stream();
    test_window();
    test_full();
    test_pause();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
